// File: rtl/xpmwrap_pkg.sv
// Shared types and width helpers for the xpmwrap RAM reader.
// Imported by the reader top and its output FIFO.
package xpmwrap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } rd_state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xpmwrap_sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push and pop in the same cycle both take effect.
module xpmwrap_sync_fifo
   import xpmwrap_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33,
   localparam int CW = cnt_width(DEPTH),
   localparam int PW = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= bump(wp);
         if (pop)  rp <= bump(rp);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   assign dout  = mem[rp];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/xpmwrap_spram_reader.sv
// Burst read master for the xpmwrap single-port RAM: issues reads,
// absorbs RAM latency and streams the data out with tlast.
module xpmwrap_spram_reader
   import xpmwrap_pkg::*;
#(
   parameter int ADDR_WIDTH_A = 6,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH_A-1:0] cmd_addr,
   input  logic [ADDR_WIDTH_A:0] cmd_len,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH_A-1:0] mem_addra,
   output logic                  mem_ena,
   output logic                  mem_wea,
   output logic                  mem_regcea,
   output logic                  mem_rsta,
   input  logic [DATA_WIDTH-1:0] mem_douta
);

   localparam int LW = ADDR_WIDTH_A + 1;
   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int IW = cnt_width(READ_LATENCY);

   rd_state_e state;
   rd_state_e nxt;

   logic [ADDR_WIDTH_A-1:0] addr;
   logic [LW-1:0]           rem;
   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0] pl;
   logic [IW-1:0]           inflight;
   logic [CW-1:0]           fcount;
   logic                    ffull;
   logic                    fempty;
   logic                    accept;
   logic                    issue;
   logic                    last_issue;
   logic                    push;
   logic                    pop;
   logic [DATA_WIDTH:0]     fdout;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++)
         inflight = inflight + IW'(pv[i]);
   end

   assign accept     = cmd_valid && cmd_ready;
   // Credits count both buffered beats and reads still in the RAM pipe.
   assign issue      = (state == RUN) && (rem != '0) &&
                       ((int'(fcount) + int'(inflight)) < FIFO_DEPTH);
   assign last_issue = issue && (rem == LW'(1));

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (accept)
               nxt = (cmd_len == '0) ? DONE : RUN;
         RUN:
            if (last_issue) nxt = DRAIN;
         DRAIN:
            if ((inflight == '0) && fempty) nxt = DONE;
         DONE:
            nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
   end

   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         state <= IDLE;
         addr  <= '0;
         rem   <= '0;
         pv    <= '0;
         pl    <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            addr <= cmd_addr;
            rem  <= cmd_len;
         end else if (issue) begin
            addr <= addr + ADDR_WIDTH_A'(1);
            rem  <= rem - LW'(1);
         end
         pv[0] <= issue;
         pl[0] <= last_issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pl[i] <= pl[i-1];
         end
      end
   end

   assign push = pv[READ_LATENCY-1];
   assign pop  = m_tvalid && m_tready;

   xpmwrap_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk   (clka),
      .rst_n (rsta_n),
      .push  (push),
      .din   ({pl[READ_LATENCY-1], mem_douta}),
      .pop   (pop),
      .dout  (fdout),
      .count (fcount),
      .full  (ffull),
      .empty (fempty)
   );

   always_ff @(posedge clka) begin
      if (rsta_n)
         assert (!(push && ffull && !pop))
            else $error("reader fifo overflow");
   end

   assign m_tvalid   = !fempty;
   assign m_tdata    = fdout[DATA_WIDTH-1:0];
   assign m_tlast    = fdout[DATA_WIDTH] && !fempty;
   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign mem_addra  = addr;
   assign mem_ena    = issue;
   assign mem_wea    = 1'b0;
   assign mem_regcea = 1'b1;
   assign mem_rsta   = ~rsta_n;

endmodule

// File: tb/tb_xpmwrap_spram_reader.sv
// Scoreboard bench for xpmwrap_spram_reader with a 2-cycle RAM model.
module tb_xpmwrap_spram_reader;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int FD = 4;

   logic          clka = 1'b0;
   logic          rsta_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tlast;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addra;
   logic          mem_ena;
   logic          mem_wea;
   logic          mem_regcea;
   logic          mem_rsta;
   logic [DW-1:0] mem_douta;

   xpmwrap_spram_reader #(
      .ADDR_WIDTH_A (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (2),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clka       (clka),
      .rsta_n     (rsta_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .busy       (busy),
      .done       (done),
      .mem_addra  (mem_addra),
      .mem_ena    (mem_ena),
      .mem_wea    (mem_wea),
      .mem_regcea (mem_regcea),
      .mem_rsta   (mem_rsta),
      .mem_douta  (mem_douta)
   );

   always #5 clka = ~clka;

   // RAM model: latch stage on ena, output register on regcea
   logic [DW-1:0] ram [64];
   logic [DW-1:0] r1;
   logic [DW-1:0] r2;

   always @(posedge clka) begin
      if (mem_ena && !mem_wea) r1 <= ram[mem_addra];
      if (mem_rsta) r2 <= '0;
      else if (mem_regcea) r2 <= r1;
   end
   assign mem_douta = r2;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t         sbq[$];
   beat_t         e;
   logic [AW-1:0] alog[$];
   int            compared = 0;
   int            mismatched = 0;
   int            beats = 0;
   int            ena_cnt = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            cyc = 0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_d;
   logic          stall_l;

   always @(posedge clka) cyc++;

   always @(negedge clka) begin
      if (rsta_n) begin
         if (mem_ena) begin
            ena_cnt++;
            alog.push_back(mem_addra);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         compared++;
         if (int'(dut.fcount) + int'(dut.inflight) > FD) begin
            mismatched++;
            $display("FAIL credit: count+inflight=%0d limit %0d",
                     int'(dut.fcount) + int'(dut.inflight), FD);
         end
         if (stall_prev) begin
            compared++;
            if (!m_tvalid || m_tdata !== stall_d || m_tlast !== stall_l) begin
               mismatched++;
               $display("FAIL stall_stable: v=%0b d=%h l=%0b want v=1 d=%h l=%0b",
                        m_tvalid, m_tdata, m_tlast, stall_d, stall_l);
            end
         end
         if (m_tvalid && m_tready) begin
            beats++;
            compared++;
            if (sbq.size() == 0) begin
               mismatched++;
               $display("FAIL beat: unexpected d=%h l=%0b want no beat",
                        m_tdata, m_tlast);
            end else begin
               e = sbq.pop_front();
               if (m_tdata !== e.d || m_tlast !== e.l) begin
                  mismatched++;
                  $display("FAIL beat: got d=%h l=%0b want d=%h l=%0b",
                           m_tdata, m_tlast, e.d, e.l);
               end
            end
         end
         stall_prev = m_tvalid && !m_tready;
         stall_d    = m_tdata;
         stall_l    = m_tlast;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input int len,
                           input bit keep, output int acc);
      logic [AW-1:0] ea;
      int n;
      cmd_addr  = a;
      cmd_len   = (AW+1)'(len);
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 300) begin
         tick();
         n++;
      end
      compared++;
      if (!cmd_ready) begin
         mismatched++;
         $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles want 1",
                  cmd_ready, n);
      end
      for (int i = 0; i < len; i++) begin
         ea = a + AW'(i);
         sbq.push_back('{d: ram[ea], l: (i == len - 1)});
      end
      tick();
      acc = cyc;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int lim);
      int n;
      n = 0;
      while (done_cnt == d0 && n < lim) begin
         tick();
         n++;
      end
      compared++;
      if (done_cnt == d0) begin
         mismatched++;
         $display("FAIL done_wait: no done after %0d cycles want pulse", n);
      end
   endtask

   task automatic test_reset();
      rsta_n = 1'b0;
      tick();
      tick();
      compared++;
      if ({cmd_ready, m_tvalid, m_tlast, busy, done, mem_ena} !== 6'b100000) begin
         mismatched++;
         $display("FAIL reset_flags: rdy,v,l,busy,done,ena=%b want 100000",
                  {cmd_ready, m_tvalid, m_tlast, busy, done, mem_ena});
      end
      compared++;
      if (mem_addra !== '0) begin
         mismatched++;
         $display("FAIL reset_addr: got %0d want 0", mem_addra);
      end
      compared++;
      if ({mem_wea, mem_regcea, mem_rsta} !== 3'b011) begin
         mismatched++;
         $display("FAIL reset_ties: wea,regcea,rsta=%b want 011",
                  {mem_wea, mem_regcea, mem_rsta});
      end
      rsta_n = 1'b1;
      tick();
      compared++;
      if (mem_rsta !== 1'b0 || cmd_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_release: rsta=%0b rdy=%0b want 0 1",
                  mem_rsta, cmd_ready);
      end
   endtask

   task automatic test_basic();
      int d0, b0, acc, n;
      for (int i = 0; i < 4; i++) ram[5+i] = 32'hA0 + i;
      m_tready = 1'b1;
      d0 = done_cnt;
      b0 = beats;
      ena_cnt = 0;
      send_cmd(6'd5, 4, 1'b0, acc);
      n = 0;
      while (!m_tvalid && n < 20) begin
         tick();
         n++;
      end
      compared++;
      if (n !== 3) begin
         mismatched++;
         $display("FAIL basic_latency: got %0d want 3", n);
      end
      wait_done(d0, 50);
      repeat (3) tick();
      compared++;
      if (done_cnt - d0 !== 1) begin
         mismatched++;
         $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
      end
      compared++;
      if (beats - b0 !== 4 || sbq.size() !== 0) begin
         mismatched++;
         $display("FAIL basic_beats: got %0d left %0d want 4 left 0",
                  beats - b0, sbq.size());
      end
      compared++;
      if (ena_cnt !== 4) begin
         mismatched++;
         $display("FAIL basic_reads: got %0d want 4", ena_cnt);
      end
   endtask

   task automatic test_wrap();
      int d0, acc;
      logic [AW-1:0] ea;
      m_tready = 1'b1;
      d0 = done_cnt;
      alog.delete();
      send_cmd(6'd62, 4, 1'b0, acc);
      wait_done(d0, 50);
      tick();
      compared++;
      if (alog.size() !== 4) begin
         mismatched++;
         $display("FAIL wrap_count: got %0d want 4", alog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            ea = 6'd62 + AW'(i);
            compared++;
            if (alog[i] !== ea) begin
               mismatched++;
               $display("FAIL wrap_addr%0d: got %0d want %0d", i, alog[i], ea);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int d0, b0, acc, n;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      d0 = done_cnt;
      b0 = beats;
      ena_cnt = 0;
      m_tready = ($urandom_range(0, 9) >= 3);
      send_cmd(6'd20, 16, 1'b0, acc);
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         m_tready = ($urandom_range(0, 9) >= 3);
         tick();
         n++;
      end
      m_tready = 1'b1;
      compared++;
      if (done_cnt == d0) begin
         mismatched++;
         $display("FAIL bp_done: no done after %0d cycles want pulse", n);
      end
      tick();
      compared++;
      if (beats - b0 !== 16 || sbq.size() !== 0) begin
         mismatched++;
         $display("FAIL bp_beats: got %0d left %0d want 16 left 0",
                  beats - b0, sbq.size());
      end
      compared++;
      if (ena_cnt !== 16) begin
         mismatched++;
         $display("FAIL bp_reads: got %0d want 16", ena_cnt);
      end
   endtask

   task automatic test_zero_full();
      int d0, b0, acc;
      bit seen [64];
      int distinct;
      m_tready = 1'b1;
      d0 = done_cnt;
      b0 = beats;
      ena_cnt = 0;
      send_cmd(6'd7, 0, 1'b0, acc);
      wait_done(d0, 4);
      repeat (3) tick();
      compared++;
      if (done_cyc - acc > 2 || done_cyc < acc) begin
         mismatched++;
         $display("FAIL zero_timing: done at +%0d want <=2", done_cyc - acc);
      end
      compared++;
      if (ena_cnt !== 0 || beats !== b0 || done_cnt - d0 !== 1) begin
         mismatched++;
         $display("FAIL zero_len: reads=%0d beats=%0d dones=%0d want 0 0 1",
                  ena_cnt, beats - b0, done_cnt - d0);
      end
      d0 = done_cnt;
      b0 = beats;
      alog.delete();
      send_cmd(6'd10, 64, 1'b0, acc);
      wait_done(d0, 300);
      tick();
      compared++;
      if (beats - b0 !== 64 || sbq.size() !== 0) begin
         mismatched++;
         $display("FAIL full_beats: got %0d left %0d want 64 left 0",
                  beats - b0, sbq.size());
      end
      distinct = 0;
      foreach (alog[i]) begin
         if (!seen[alog[i]]) distinct++;
         seen[alog[i]] = 1'b1;
      end
      compared++;
      if (distinct !== 64 || alog.size() !== 64 || alog[0] !== 6'd10) begin
         mismatched++;
         $display("FAIL full_addrs: distinct=%0d reads=%0d want 64 64",
                  distinct, alog.size());
      end
   endtask

   task automatic test_reset_mid();
      int d0, b0, acc, n;
      m_tready = 1'b1;
      b0 = beats;
      send_cmd(6'd30, 16, 1'b0, acc);
      n = 0;
      while (beats - b0 < 3 && n < 50) begin
         tick();
         n++;
      end
      compared++;
      if (beats - b0 < 3) begin
         mismatched++;
         $display("FAIL mid_progress: got %0d beats want 3", beats - b0);
      end
      rsta_n = 1'b0;
      tick();
      compared++;
      if (m_tvalid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset: v=%0b rdy=%0b busy=%0b want 0 1 0",
                  m_tvalid, cmd_ready, busy);
      end
      rsta_n = 1'b1;
      sbq.delete();
      d0 = done_cnt;
      b0 = beats;
      repeat (10) tick();
      compared++;
      if (done_cnt !== d0 || beats !== b0) begin
         mismatched++;
         $display("FAIL mid_abort: dones=%0d beats=%0d want 0 0",
                  done_cnt - d0, beats - b0);
      end
      send_cmd(6'd40, 5, 1'b0, acc);
      wait_done(d0, 50);
      tick();
      compared++;
      if (beats - b0 !== 5 || sbq.size() !== 0) begin
         mismatched++;
         $display("FAIL mid_after: got %0d left %0d want 5 left 0",
                  beats - b0, sbq.size());
      end
   endtask

   task automatic test_back_to_back();
      int d0, b0, acc1, acc2, first_done;
      for (int i = 0; i < 64; i++) ram[i] = 32'h5500_0000 | i;
      m_tready = 1'b1;
      d0 = done_cnt;
      b0 = beats;
      send_cmd(6'd50, 3, 1'b1, acc1);
      send_cmd(6'd60, 6, 1'b0, acc2);
      first_done = done_cyc;
      compared++;
      if (done_cnt - d0 !== 1 || acc2 <= first_done) begin
         mismatched++;
         $display("FAIL b2b_order: dones=%0d acc2=%0d done=%0d want 1 and acc2>done",
                  done_cnt - d0, acc2, first_done);
      end
      wait_done(d0 + 1, 80);
      tick();
      compared++;
      if (beats - b0 !== 9 || sbq.size() !== 0) begin
         mismatched++;
         $display("FAIL b2b_beats: got %0d left %0d want 9 left 0",
                  beats - b0, sbq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'hC000_0000 | i;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_full();
      test_reset_mid();
      test_back_to_back();
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
